car_move_ctl: RTL and testbench

Player-car movement controller for the Death Race game. It decodes the PS/2 keyboard scan-code byte stream into held-arrow-key state, including make, break and extended prefixes. Once per frame, on the vsync rising edge, it steps the car position with an acceleration ramp and clamps the result to the playfield. Its outputs feed the rectangle/sprite draw stage as xpos_out/ypos_out.

---
 rtl/car_move_ctl.sv | 154 +++++++++++++++
 tb/tb_car_move_ctl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_move_ctl.sv
// Player-car movement controller: decodes PS/2 arrow-key make/break codes into
// held-key state and steps a clamped car position once per vsync rising edge.
module car_move_ctl #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 784,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 584,
  parameter int X_INIT       = 400,
  parameter int Y_INIT       = 536,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [7:0]  data,
  input  logic        vsync,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic [2:0]  speed,
  output logic [3:0]  keys_held,
  output logic        frame_tick
);

  localparam int ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(ACCEL_FRAMES - 1);
  localparam logic [2:0]       SPEED_MAX = 3'(MAX_SPEED);
  localparam logic signed [12:0] X_LO = 13'(X_MIN);
  localparam logic signed [12:0] X_HI = 13'(X_MAX);
  localparam logic signed [12:0] Y_LO = 13'(Y_MIN);
  localparam logic signed [12:0] Y_HI = 13'(Y_MAX);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  dec_state_t       state, state_next;
  logic [3:0]       keys_next;
  logic             vsync_d;
  logic [ACC_W-1:0] acc, acc_next;
  logic [2:0]       speed_next, step_sz;
  logic [11:0]      xpos_next, ypos_next;
  logic             up_mv, dn_mv, lf_mv, rt_mv, moving;

  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    case (code)
      8'h75:   return 4'b0001;
      8'h72:   return 4'b0010;
      8'h6B:   return 4'b0100;
      8'h74:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic signed [12:0] step_axis(input logic [11:0] pos,
                                                   input logic neg, input logic pos_dir,
                                                   input logic [2:0] step);
    logic signed [12:0] p;
    logic signed [12:0] s;
    p = $signed({1'b0, pos});
    s = $signed({10'd0, step});
    if (neg)          return p - s;
    else if (pos_dir) return p + s;
    else              return p;
  endfunction

  // Saturate to the playfield; the 13-bit signed sum keeps 0-1 from wrapping.
  function automatic logic [11:0] clamp_pos(input logic signed [12:0] v,
                                            input logic signed [12:0] lo,
                                            input logic signed [12:0] hi);
    if (v < lo)      return lo[11:0];
    else if (v > hi) return hi[11:0];
    else             return v[11:0];
  endfunction

  // Scan-code decoder: consumes one byte per data_valid strobe.
  always_comb begin
    state_next = state;
    keys_next  = keys_held;
    if (data_valid) begin
      case (state)
        IDLE: begin
          if (data == 8'hE0)      state_next = EXT;
          else if (data == 8'hF0) state_next = BRK;
          else                    state_next = IDLE;
        end
        EXT: begin
          if (data == 8'hF0) begin
            state_next = EXT_BRK;
          end else begin
            keys_next  = keys_held | arrow_mask(data);
            state_next = IDLE;
          end
        end
        BRK: state_next = IDLE;
        EXT_BRK: begin
          keys_next  = keys_held & ~arrow_mask(data);
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign up_mv  = keys_held[0] & ~keys_held[1];
  assign dn_mv  = keys_held[1] & ~keys_held[0];
  assign lf_mv  = keys_held[2] & ~keys_held[3];
  assign rt_mv  = keys_held[3] & ~keys_held[2];
  assign moving = up_mv | dn_mv | lf_mv | rt_mv;

  // Frame step: speed ramp and clamped position for the tick cycle.
  always_comb begin
    step_sz    = (speed == 3'd0) ? 3'd1 : speed;
    speed_next = speed;
    acc_next   = acc;
    if (!moving) begin
      speed_next = 3'd0;
      acc_next   = '0;
    end else if (speed == 3'd0) begin
      speed_next = 3'd1;
      acc_next   = '0;
    end else if (acc == ACC_LAST) begin
      acc_next   = '0;
      speed_next = (speed >= SPEED_MAX) ? SPEED_MAX : speed + 3'd1;
    end else begin
      acc_next   = acc + ACC_W'(1);
    end
    xpos_next = clamp_pos(step_axis(xpos_out, lf_mv, rt_mv, step_sz), X_LO, X_HI);
    ypos_next = clamp_pos(step_axis(ypos_out, up_mv, dn_mv, step_sz), Y_LO, Y_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      keys_held  <= 4'b0000;
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
      xpos_out   <= 12'(X_INIT);
      ypos_out   <= 12'(Y_INIT);
      speed      <= 3'd0;
      acc        <= '0;
    end else begin
      state      <= state_next;
      keys_held  <= keys_next;
      vsync_d    <= vsync;
      frame_tick <= vsync & ~vsync_d;
      if (frame_tick) begin
        xpos_out <= xpos_next;
        ypos_out <= ypos_next;
        speed    <= speed_next;
        acc      <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_car_move_ctl.sv
// Bench for car_move_ctl: decoder vector table, directed frame sequences and
// randomized key/vsync traffic checked against an event-level reference model.
module tb_car_move_ctl;

  localparam int XMIN = 0, XMAX = 784, YMIN = 0, YMAX = 584;
  localparam int XINIT = 400, YINIT = 536, MAXSPD = 4, AF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        vsync = 1'b0;
  logic [11:0] xpos_out, ypos_out;
  logic [2:0]  speed;
  logic [3:0]  keys_held;
  logic        frame_tick;

  car_move_ctl dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .vsync(vsync),
    .xpos_out(xpos_out), .ypos_out(ypos_out), .speed(speed),
    .keys_held(keys_held), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: held-key set, pending prefix flags, position and the
  // length of the current run of moving frames (speed derives from it).
  int       mx, my, mspd, mrun;
  logic [3:0] mkeys;
  bit       mext, mbrk;

  typedef struct {
    logic [7:0] b;
    logic [3:0] keys;
  } dec_vec_t;
  dec_vec_t vecs [36];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [3:0] key_of(input logic [7:0] b);
    if (b == 8'h75) return 4'b0001;
    if (b == 8'h72) return 4'b0010;
    if (b == 8'h6B) return 4'b0100;
    if (b == 8'h74) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    mx = XINIT; my = YINIT; mspd = 0; mrun = 0;
    mkeys = 4'b0000; mext = 0; mbrk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!mext && !mbrk) begin
      if (b == 8'hE0) mext = 1;
      else if (b == 8'hF0) mbrk = 1;
    end else if (mext && !mbrk) begin
      if (b == 8'hF0) mbrk = 1;
      else begin mkeys = mkeys | key_of(b); mext = 0; end
    end else if (!mext && mbrk) begin
      mbrk = 0;
    end else begin
      mkeys = mkeys & ~key_of(b);
      mext = 0; mbrk = 0;
    end
  endtask

  task automatic model_tick();
    int dx, dy, step;
    dy = (mkeys[0] == mkeys[1]) ? 0 : (mkeys[0] ? -1 : 1);
    dx = (mkeys[2] == mkeys[3]) ? 0 : (mkeys[2] ? -1 : 1);
    if (dx == 0 && dy == 0) begin
      mrun = 0; mspd = 0;
    end else begin
      mrun++;
      step = (mrun == 1) ? 1 : imin(1 + (mrun - 2) / AF, MAXSPD);
      mspd = imin(1 + (mrun - 1) / AF, MAXSPD);
      mx = clampi(mx + dx * step, XMIN, XMAX);
      my = clampi(my + dy * step, YMIN, YMAX);
    end
  endtask

  task automatic do_reset(input logic vs);
    @(negedge clk);
    rst = 1'b1; vsync = vs; data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_valid = 1'b1; data = b;
    @(negedge clk);
    data_valid = 1'b0; data = 8'h00;
    model_byte(b);
  endtask

  task automatic pulse();
    int ticks;
    ticks = 0;
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) begin @(negedge clk); if (frame_tick) ticks++; end
    vsync = 1'b0;
    repeat (2) begin @(negedge clk); if (frame_tick) ticks++; end
    check("frame_tick_count", ticks, 1);
    model_tick();
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_x"}, int'(xpos_out), mx);
    check({tag, "_y"}, int'(ypos_out), my);
    check({tag, "_speed"}, int'(speed), mspd);
    check({tag, "_keys"}, int'(keys_held), int'(mkeys));
  endtask

  initial begin
    int ticks, maxspd;
    logic [7:0] pool [8];

    vecs[0]  = '{8'hE0, 4'b0000}; vecs[1]  = '{8'h75, 4'b0001};
    vecs[2]  = '{8'hF0, 4'b0001}; vecs[3]  = '{8'h75, 4'b0001};
    vecs[4]  = '{8'hE0, 4'b0001}; vecs[5]  = '{8'h6B, 4'b0101};
    vecs[6]  = '{8'hE0, 4'b0101}; vecs[7]  = '{8'h74, 4'b1101};
    vecs[8]  = '{8'hE0, 4'b1101}; vecs[9]  = '{8'hF0, 4'b1101};
    vecs[10] = '{8'h6B, 4'b1001}; vecs[11] = '{8'h12, 4'b1001};
    vecs[12] = '{8'hE0, 4'b1001}; vecs[13] = '{8'h12, 4'b1001};
    vecs[14] = '{8'h72, 4'b1001}; vecs[15] = '{8'hE0, 4'b1001};
    vecs[16] = '{8'h72, 4'b1011}; vecs[17] = '{8'hE0, 4'b1011};
    vecs[18] = '{8'hF0, 4'b1011}; vecs[19] = '{8'h75, 4'b1010};
    vecs[20] = '{8'hE0, 4'b1010}; vecs[21] = '{8'hF0, 4'b1010};
    vecs[22] = '{8'h12, 4'b1010}; vecs[23] = '{8'h75, 4'b1010};
    vecs[24] = '{8'hE0, 4'b1010}; vecs[25] = '{8'hF0, 4'b1010};
    vecs[26] = '{8'h74, 4'b0010}; vecs[27] = '{8'hE0, 4'b0010};
    vecs[28] = '{8'hF0, 4'b0010}; vecs[29] = '{8'h72, 4'b0000};
    vecs[30] = '{8'hF0, 4'b0000}; vecs[31] = '{8'hE0, 4'b0000};
    vecs[32] = '{8'h75, 4'b0000}; vecs[33] = '{8'hE0, 4'b0000};
    vecs[34] = '{8'hE0, 4'b0000}; vecs[35] = '{8'h75, 4'b0000};

    // Reset with vsync already high: no tick after release.
    do_reset(1'b1);
    ticks = 0;
    repeat (10) begin @(negedge clk); if (frame_tick) ticks++; end
    check("no_tick_after_reset", ticks, 0);
    check("reset_x", int'(xpos_out), 400);
    check("reset_y", int'(ypos_out), 536);
    check("reset_speed", int'(speed), 0);
    check("reset_keys", int'(keys_held), 0);
    vsync = 1'b0;

    // Decoder vector table.
    do_reset(1'b0);
    for (int i = 0; i < 36; i++) begin
      send_byte(vecs[i].b);
      check($sformatf("dec_vec%0d", i), int'(keys_held), int'(vecs[i].keys));
    end

    // Up held for 10 frames.
    do_reset(1'b0);
    send_byte(8'hE0); send_byte(8'h75);
    check("up_keys", int'(keys_held), 1);
    for (int i = 1; i <= 10; i++) begin
      pulse();
      if (i == 9) check("up_tick9_y", int'(ypos_out), 527);
    end
    check("up10_y", int'(ypos_out), 525);
    check("up10_x", int'(xpos_out), 400);
    check("up10_speed", int'(speed), 2);

    // Extended release stops; plain release is ignored.
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    pulse();
    check("rel_keys", int'(keys_held), 0);
    check("rel_speed", int'(speed), 0);
    check("rel_y", int'(ypos_out), 525);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hF0); send_byte(8'h75);
    check("plain_break_keeps_up", int'(keys_held), 1);

    // Down into the bottom bound.
    do_reset(1'b0);
    send_byte(8'hE0); send_byte(8'h72);
    maxspd = 0;
    for (int i = 1; i <= 30; i++) begin
      pulse();
      if (int'(speed) > maxspd) maxspd = int'(speed);
      if (i == 24) check("down_tick24_y", int'(ypos_out), 582);
      if (i == 25) check("down_tick25_y", int'(ypos_out), 584);
    end
    check("down30_y", int'(ypos_out), 584);
    check("down30_speed", int'(speed), 4);
    check("down_max_speed", maxspd, 4);

    // Opposing keys cancel; diagonal moves equal steps.
    do_reset(1'b0);
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'h72);
    repeat (5) pulse();
    check("updown_y", int'(ypos_out), 536);
    check("updown_speed", int'(speed), 0);
    do_reset(1'b0);
    send_byte(8'hE0); send_byte(8'h6B); send_byte(8'hE0); send_byte(8'h75);
    repeat (3) pulse();
    check("diag_x", int'(xpos_out), 397);
    check("diag_y", int'(ypos_out), 533);

    // Final key byte lands in the tick cycle: takes effect next frame.
    do_reset(1'b0);
    send_byte(8'hE0);
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    check("same_cycle_tick_high", int'(frame_tick), 1);
    data_valid = 1'b1; data = 8'h75;
    @(negedge clk);
    data_valid = 1'b0; data = 8'h00;
    model_tick(); model_byte(8'h75);
    check("same_cycle_keys", int'(keys_held), 1);
    check("same_cycle_y", int'(ypos_out), 536);
    check("same_cycle_speed", int'(speed), 0);
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    pulse();
    check("next_frame_y", int'(ypos_out), 535);
    check("next_frame_speed", int'(speed), 1);

    // Reset mid-move, and reset discards a pending prefix.
    pulse(); pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_x", int'(xpos_out), 400);
    check("midrst_y", int'(ypos_out), 536);
    check("midrst_speed", int'(speed), 0);
    check("midrst_keys", int'(keys_held), 0);
    send_byte(8'hE0);
    do_reset(1'b0);
    send_byte(8'h75);
    check("rst_drops_prefix", int'(keys_held), 0);

    // Randomized traffic against the model.
    do_reset(1'b0);
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h75; pool[3] = 8'h72;
    pool[4] = 8'h6B; pool[5] = 8'h74; pool[6] = 8'hE0; pool[7] = 8'h12;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 5) begin
        logic [7:0] b;
        b = ($urandom_range(0, 15) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
        send_byte(b);
        check($sformatf("rnd%0d_keys", n), int'(keys_held), int'(mkeys));
      end else begin
        pulse();
        compare_model($sformatf("rnd%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
